byte_scan_reader: RTL and testbench

- Clocked read-side sequencer for the 4 x 8-bit byte memory bank.
- On a start pulse, walks addresses 0..DEPTH-1 and fetches each byte through a combinational read port.
- Presents each byte on a valid/ready output stream, tagged with its address.
- Inserts a programmable dwell gap between bytes so an LED or display consumer can show each one.

---
 rtl/byte_scan_reader.sv | 151 +++++++++++++++
 tb/tb_byte_scan_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_scan_reader.sv
// byte_scan_reader: read-side sequencer for a small byte memory bank.
// On start it walks addresses 0..DEPTH-1 through a combinational read port.
// Each byte is presented on a valid/ready stream tagged with its address.
// A programmable dwell gap follows each accepted byte.
// Optional macro BYTE_SCAN_CONTINUOUS_EN: wrap back to address 0 after the
// last byte instead of returning to IDLE; scanning repeats until abort/reset.
//
// Stream handshake: out_data/out_addr are held stable while out_valid is high.
// A byte transfers on any rising edge where out_valid && out_ready.
// out_valid never depends combinationally on out_ready.
// dbg_state mirrors the FSM state register for observation.

module byte_scan_reader #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 2,
    parameter int DWELL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_PRESENT = 3'd2,
        S_DWELL   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Dwell counter is never used when DWELL_CYCLES is 0; keep it 1 bit wide then.
    localparam int CNT_W = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] dwell_cnt;
    logic             xfer;
    logic             last_byte;

    assign xfer      = out_valid && out_ready;
    assign last_byte = (out_addr == LAST_ADDR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort outranks a simultaneous transfer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                next_state = abort ? S_IDLE : S_PRESENT;
            end
            S_PRESENT: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (xfer) begin
                    if (last_byte) begin
                        next_state = S_DONE;
                    end else if (DWELL_CYCLES == 0) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (dwell_cnt <= CNT_W'(1)) begin
                    next_state = S_FETCH;
                end
            end
            S_DONE: begin
`ifdef BYTE_SCAN_CONTINUOUS_EN
                next_state = S_FETCH;
`else
                next_state = S_IDLE;
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Registered datapath: address walk, byte capture, valid flag, dwell count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            // Entering FETCH from the scan steps the address; from IDLE or
            // a continuous-mode wrap it restarts at 0.
            if (next_state == S_FETCH) begin
                if (state == S_PRESENT || state == S_DWELL) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end else begin
                    rd_addr <= '0;
                end
            end

            if (state == S_FETCH && next_state == S_PRESENT) begin
                out_data <= rd_data;
                out_addr <= rd_addr;
            end

            out_valid <= (next_state == S_PRESENT);

            if (next_state == S_IDLE) begin
                dwell_cnt <= '0;
            end else if (state == S_PRESENT && next_state == S_DWELL) begin
                dwell_cnt <= DWELL_LOAD;
            end else if (state == S_DWELL && dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - CNT_W'(1);
            end
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_byte_scan_reader.sv
// Directed self-checking bench for byte_scan_reader.
// dut uses DWELL_CYCLES=4, dut_z uses DWELL_CYCLES=0; both share clock/reset.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_byte_scan_reader;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_PRESENT = 3'd2;
    localparam logic [2:0] ST_DWELL   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, out_ready, out_valid, busy, done;
    logic [1:0] rd_addr, out_addr;
    logic [7:0] rd_data, out_data;
    logic [2:0] dbg_state;

    logic       start_z, abort_z, ready_z, valid_z, busy_z, done_z;
    logic [1:0] rd_addr_z, out_addr_z;
    logic [7:0] rd_data_z, out_data_z;
    logic [2:0] state_z;

    logic [7:0] mem [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rd_data   = mem[rd_addr];
    assign rd_data_z = mem[rd_addr_z];

    byte_scan_reader #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .DWELL_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    byte_scan_reader #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .DWELL_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .abort(abort_z),
        .rd_addr(rd_addr_z), .rd_data(rd_data_z),
        .out_data(out_data_z), .out_addr(out_addr_z), .out_valid(valid_z),
        .out_ready(ready_z), .busy(busy_z), .done(done_z), .dbg_state(state_z)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_z = 1'b0; abort_z = 1'b0; ready_z = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (rd_addr !== 2'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_addr !== 2'd0) begin failures++; $display("FAIL reset_out_addr got=%0d exp=0", out_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (busy_z !== 1'b0 || valid_z !== 1'b0) begin failures++; $display("FAIL reset_dut_z busy=%b valid=%b exp=0/0", busy_z, valid_z); end
    endtask

    // One-shot scan with dwell 4: bytes presented at cycles 1,7,13,19 after
    // the start-sampling edge, 4 DWELL cycles per gap, done at cycle 20.
    task automatic test_oneshot();
        int   pres_cyc [4] = '{-1, -1, -1, -1};
        int   n_pres = 0;
        int   dwell_cnt = 0;
        int   done_cnt = 0;
        int   done_cyc = -1;
        logic busy_after = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (out_valid) begin
                if (n_pres < 4) begin
                    checks++; if (out_addr !== 2'(n_pres)) begin failures++; $display("FAIL oneshot_addr got=%0d exp=%0d", out_addr, n_pres); end
                    checks++; if (out_data !== mem[n_pres]) begin failures++; $display("FAIL oneshot_data got=%h exp=%h", out_data, mem[n_pres]); end
                    pres_cyc[n_pres] = cyc;
                end
                n_pres++;
            end
            if (dbg_state == ST_DWELL) dwell_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checks++; if (rd_addr !== 2'd3 || out_addr !== 2'd3) begin failures++; $display("FAIL oneshot_done_addr got=%0d/%0d exp=3/3", rd_addr, out_addr); end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            step();
        end
        checks++; if (n_pres !== 4) begin failures++; $display("FAIL oneshot_count got=%0d exp=4", n_pres); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (pres_cyc[k] !== 1 + 6 * k) begin failures++; $display("FAIL oneshot_timing byte=%0d got=%0d exp=%0d", k, pres_cyc[k], 1 + 6 * k); end
        end
        checks++; if (dwell_cnt !== 12) begin failures++; $display("FAIL oneshot_dwell_cycles got=%0d exp=12", dwell_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL oneshot_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc !== 20) begin failures++; $display("FAIL oneshot_done_cycle got=%0d exp=20", done_cyc); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL oneshot_busy_after_done got=%b exp=0", busy_after); end
    endtask

    task automatic test_backpressure();
        logic found = 1'b0;
        logic seen_done = 1'b0;
        int   bad = 0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_addr == 2'd1) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin failures++; $display("FAIL bp_wait_addr1 got=timeout exp=valid addr1"); end
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== 8'h22 || out_addr !== 2'd1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || dbg_state !== ST_DWELL) begin failures++; $display("FAIL bp_release valid=%b state=%0d exp=0/%0d", out_valid, dbg_state, ST_DWELL); end
        for (int i = 0; i < 60 && !seen_done; i++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        checks++; if (!seen_done || busy !== 1'b0) begin failures++; $display("FAIL bp_finish done_seen=%b busy=%b exp=1/0", seen_done, busy); end
    endtask

    task automatic test_abort();
        logic found = 1'b0;
        int   stray = 0;
        out_ready = 1'b1;
        // abort is ignored in IDLE, start still honoured
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++; if (dbg_state !== ST_FETCH || busy !== 1'b1) begin failures++; $display("FAIL abort_idle_ignored state=%0d busy=%b exp=%0d/1", dbg_state, busy, ST_FETCH); end
        // abort in FETCH
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (dbg_state !== ST_IDLE || out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_fetch state=%0d valid=%b done=%b exp=0/0/0", dbg_state, out_valid, done); end
        // full scan, start ignored while busy, abort in DWELL after address 2
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_addr == 2'd1) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin failures++; $display("FAIL abort_wait_addr1 got=timeout exp=valid addr1"); end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (dbg_state !== ST_DWELL || busy !== 1'b1) begin failures++; $display("FAIL start_while_busy state=%0d busy=%b exp=%0d/1", dbg_state, busy, ST_DWELL); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else step();
        end
        checks++; if (!found || out_addr !== 2'd2 || out_data !== 8'h33) begin failures++; $display("FAIL start_while_busy_next addr=%0d data=%h exp=2/33", out_addr, out_data); end
        step();
        checks++; if (dbg_state !== ST_DWELL) begin failures++; $display("FAIL abort_pre_state got=%0d exp=%0d", dbg_state, ST_DWELL); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_dwell state=%0d busy=%b valid=%b done=%b exp=0/0/0/0", dbg_state, busy, out_valid, done); end
        for (int i = 0; i < 30; i++) begin
            if (out_valid || done || busy) stray++;
            step();
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL abort_quiet got=%0d active cycles exp=0", stray); end
    endtask

    // Dwell 0: bytes at cycles 1,3,5,7, done at cycle 8 (the start cycle plus
    // 8 more gives 9 cycles from start to done).
    task automatic test_dwell0();
        int   pres_cyc [4] = '{-1, -1, -1, -1};
        int   n_pres = 0;
        int   done_cyc = -1;
        logic busy_after = 1'b1;
        ready_z = 1'b1;
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (valid_z) begin
                if (n_pres < 4) begin
                    pres_cyc[n_pres] = cyc;
                    checks++; if (out_addr_z !== 2'(n_pres) || out_data_z !== mem[n_pres]) begin failures++; $display("FAIL dwell0_byte addr=%0d data=%h exp=%0d/%h", out_addr_z, out_data_z, n_pres, mem[n_pres]); end
                end
                n_pres++;
            end
            if (done_z) done_cyc = cyc;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy_z;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (pres_cyc[k] !== 1 + 2 * k) begin failures++; $display("FAIL dwell0_timing byte=%0d got=%0d exp=%0d", k, pres_cyc[k], 1 + 2 * k); end
        end
        checks++; if (done_cyc !== 8) begin failures++; $display("FAIL dwell0_done_cycle got=%0d exp=8", done_cyc); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL dwell0_busy_after_done got=%b exp=0", busy_after); end
    endtask

    task automatic test_continuous();
        int   done_cnt = 0;
        int   done_cyc = -1;
        int   busy_low = 0;
        logic checked_wrap = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!busy) busy_low++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (done_cyc >= 0 && !checked_wrap && out_valid) begin
                checked_wrap = 1'b1;
                checks++; if (cyc !== 22 || out_addr !== 2'd0 || out_data !== 8'h11) begin failures++; $display("FAIL cont_wrap cyc=%0d addr=%0d data=%h exp=22/0/11", cyc, out_addr, out_data); end
            end
            step();
        end
        checks++; if (done_cyc !== 20 || done_cnt !== 1) begin failures++; $display("FAIL cont_done cyc=%0d count=%0d exp=20/1", done_cyc, done_cnt); end
        checks++; if (!checked_wrap) begin failures++; $display("FAIL cont_wrap_seen got=0 exp=1"); end
        checks++; if (busy_low !== 0) begin failures++; $display("FAIL cont_busy got=%0d low cycles exp=0", busy_low); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL cont_abort state=%0d busy=%b valid=%b exp=0/0/0", dbg_state, busy, out_valid); end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        int   stray = 0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_addr == 2'd1) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin failures++; $display("FAIL rstmid_wait_addr1 got=timeout exp=valid addr1"); end
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl valid=%b busy=%b done=%b exp=0/0/0", out_valid, busy, done); end
        checks++; if (out_data !== 8'h00 || out_addr !== 2'd0 || rd_addr !== 2'd0) begin failures++; $display("FAIL rstmid_data data=%h addr=%0d rd_addr=%0d exp=00/0/0", out_data, out_addr, rd_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy || out_valid) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", stray); end
    endtask

    initial begin
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        @(negedge clk);
        test_reset();
`ifdef BYTE_SCAN_CONTINUOUS_EN
        test_continuous();
        test_abort();
        test_reset_mid();
`else
        test_oneshot();
        test_backpressure();
        test_abort();
        test_dwell0();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
